// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, branch and data-memory wait hazards.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rd_E,
    input  logic [1:0]       result_src_E,
    input  logic             pcsrc_E,
    input  logic             mem_req_M,
    input  logic             mem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;

    logic w_lu;
    logic w_mw;
    logic w_wait_done;
    logic w_run_eval;
    logic w_hold;
    logic w_branch;
    logic w_lu_stall;
    logic w_err;

    assign w_lu = (result_src_E == 2'b01) && (Rd_E != 5'd0)
               && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    assign w_mw = mem_req_M && !mem_ready;
    // A request vanishing mid-wait is illegal; it is treated as completion so the pipe cannot lock up.
    assign w_wait_done = mem_ready || !mem_req_M;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_mw) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (w_wait_done) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt < TIMEOUT) begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end else begin
                    w_state_nxt = MEM_ERR;
                end
            end
            MEM_ERR: begin
                w_state_nxt = MEM_ERR;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // The completing MEM_WAIT cycle resolves branch/load-use exactly as RUN would.
    always_comb begin
        w_run_eval = 1'b0;
        w_hold     = 1'b0;
        w_branch   = 1'b0;
        w_lu_stall = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mw) w_hold = 1'b1;
                else      w_run_eval = 1'b1;
            end
            MEM_WAIT: begin
                if (w_wait_done) w_run_eval = 1'b1;
                else             w_hold = 1'b1;
            end
            MEM_ERR: begin
                w_hold = 1'b1;
                w_err  = 1'b1;
            end
            default: ;
        endcase
        if (w_run_eval) begin
            if (pcsrc_E)   w_branch   = 1'b1;
            else if (w_lu) w_lu_stall = 1'b1;
        end
    end

    assign stall_F = rst_n && (w_hold || w_lu_stall);
    assign stall_D = rst_n && (w_hold || w_lu_stall);
    assign stall_E = rst_n && w_hold;
    assign stall_M = rst_n && w_hold;
    assign flush_D = rst_n && w_branch;
    assign flush_E = rst_n && (w_branch || w_lu_stall);
    assign flush_W = rst_n && w_hold;
    assign mem_err = rst_n && w_err;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_F && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if ((flush_D || flush_E) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4); perf checks follow HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  Rs1_D = '0;
    logic [4:0]  Rs2_D = '0;
    logic [4:0]  Rd_E = '0;
    logic [1:0]  result_src_E = '0;
    logic        pcsrc_E = 1'b0;
    logic        mem_req_M = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_D, flush_E, flush_W, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1100_0100;
    localparam logic [7:0] BR   = 8'b0000_1100;
    localparam logic [7:0] HOLD = 8'b1111_0010;
    localparam logic [7:0] ERR  = 8'b1111_0011;

    logic [7:0] obs;
    assign obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E),
        .result_src_E(result_src_E), .pcsrc_E(pcsrc_E), .mem_req_M(mem_req_M),
        .mem_ready(mem_ready), .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .stall_M(stall_M), .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

`ifdef HAZARD_PERF_EN
    logic       s_sF, s_sD, s_sE, s_sM, s_fD, s_fE, s_fW, s_err;
    logic [1:0] sat_stall_cnt, sat_flush_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E),
        .result_src_E(result_src_E), .pcsrc_E(pcsrc_E), .mem_req_M(mem_req_M),
        .mem_ready(mem_ready), .stall_F(s_sF), .stall_D(s_sD), .stall_E(s_sE),
        .stall_M(s_sM), .flush_D(s_fD), .flush_E(s_fE), .flush_W(s_fW),
        .mem_err(s_err), .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
    );
`endif

    // One pipeline cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [1:0] rsrc, input logic pc, input logic req, input logic rdy);
        @(posedge clk);
        #1;
        Rs1_D = rs1; Rs2_D = rs2; Rd_E = rd; result_src_E = rsrc;
        pcsrc_E = pc; mem_req_M = req; mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        Rs1_D = '0; Rs2_D = '0; Rd_E = '0; result_src_E = '0;
        pcsrc_E = 1'b0; mem_req_M = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pcsrc_E = 1'b1; mem_req_M = 1'b1; mem_ready = 1'b0;
        Rd_E = 5'd3; Rs1_D = 5'd3; result_src_E = 2'b01;
        repeat (2) @(negedge clk);
        n_checks++; if (obs !== NONE) $display("FAIL reset_outputs: got %b exp %b", obs, NONE); else n_pass++;
        n_checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL reset_counters: got %0d/%0d exp 0/0", stall_cnt, flush_cnt); else n_pass++;
        do_reset();
        idle();
        n_checks++; if (obs !== NONE) $display("FAIL reset_idle: got %b exp %b", obs, NONE); else n_pass++;
    endtask

    task automatic test_load_use();
        cyc(5'd1, 5'd5, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== LU) $display("FAIL lu_rs2: got %b exp %b", obs, LU); else n_pass++;
        idle();
        n_checks++; if (obs !== NONE) $display("FAIL lu_one_bubble: got %b exp %b", obs, NONE); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== NONE) $display("FAIL lu_rd_zero: got %b exp %b", obs, NONE); else n_pass++;
        cyc(5'd7, 5'd2, 5'd7, 2'b01, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== LU) $display("FAIL lu_rs1: got %b exp %b", obs, LU); else n_pass++;
        cyc(5'd7, 5'd2, 5'd7, 2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== NONE) $display("FAIL lu_not_load: got %b exp %b", obs, NONE); else n_pass++;
    endtask

    task automatic test_branch();
        cyc(5'd1, 5'd5, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0);
        n_checks++; if (obs !== BR) $display("FAIL branch_over_lu: got %b exp %b", obs, BR); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        n_checks++; if (obs !== BR) $display("FAIL branch_plain: got %b exp %b", obs, BR); else n_pass++;
        idle();
        n_checks++; if (obs !== NONE) $display("FAIL branch_after: got %b exp %b", obs, NONE); else n_pass++;
    endtask

    task automatic test_mem_wait();
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== NONE) $display("FAIL mem_single_cycle: got %b exp %b", obs, NONE); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
            n_checks++; if (obs !== HOLD) $display("FAIL mem_wait_%0d: got %b exp %b", i, obs, HOLD); else n_pass++;
        end
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== NONE) $display("FAIL mem_ready_cycle: got %b exp %b", obs, NONE); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== NONE) $display("FAIL mem_back_to_run: got %b exp %b", obs, NONE); else n_pass++;
    endtask

    task automatic test_mem_priority();
        cyc(5'd1, 5'd5, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0);
        n_checks++; if (obs !== HOLD) $display("FAIL mw_over_branch: got %b exp %b", obs, HOLD); else n_pass++;
        cyc(5'd1, 5'd5, 5'd5, 2'b01, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== LU) $display("FAIL ready_then_lu: got %b exp %b", obs, LU); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1);
        n_checks++; if (obs !== BR) $display("FAIL ready_then_branch: got %b exp %b", obs, BR); else n_pass++;
        idle();
        n_checks++; if (obs !== NONE) $display("FAIL prio_after: got %b exp %b", obs, NONE); else n_pass++;
    endtask

    task automatic test_mem_drop();
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (obs !== HOLD) $display("FAIL drop_wait: got %b exp %b", obs, HOLD); else n_pass++;
        idle();
        n_checks++; if (obs !== NONE) $display("FAIL drop_as_ready: got %b exp %b", obs, NONE); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== NONE) $display("FAIL drop_state_run: got %b exp %b", obs, NONE); else n_pass++;
    endtask

    task automatic test_perf();
        do_reset();
        cyc(5'd1, 5'd5, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
        idle();
        cyc(5'd9, 5'd0, 5'd9, 2'b01, 1'b0, 1'b0, 1'b0);
        idle();
        repeat (3) cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle();
`ifdef HAZARD_PERF_EN
        n_checks++; if (stall_cnt !== 32'd5) $display("FAIL perf_stall: got %0d exp 5", stall_cnt); else n_pass++;
        n_checks++; if (flush_cnt !== 32'd3) $display("FAIL perf_flush: got %0d exp 3", flush_cnt); else n_pass++;
        n_checks++; if (sat_stall_cnt !== 2'd3) $display("FAIL sat_stall: got %0d exp 3", sat_stall_cnt); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle();
        n_checks++; if (flush_cnt !== 32'd4) $display("FAIL perf_flush2: got %0d exp 4", flush_cnt); else n_pass++;
        n_checks++; if (sat_flush_cnt !== 2'd3) $display("FAIL sat_flush: got %0d exp 3", sat_flush_cnt); else n_pass++;
        n_checks++; if (sat_stall_cnt !== 2'd3) $display("FAIL sat_stall_hold: got %0d exp 3", sat_stall_cnt); else n_pass++;
`else
        n_checks++; if (stall_cnt !== 32'd0) $display("FAIL perf_stall_tied: got %0d exp 0", stall_cnt); else n_pass++;
        n_checks++; if (flush_cnt !== 32'd0) $display("FAIL perf_flush_tied: got %0d exp 0", flush_cnt); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (obs !== HOLD) $display("FAIL async_pre: got %b exp %b", obs, HOLD); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (obs !== NONE) $display("FAIL async_immediate: got %b exp %b", obs, NONE); else n_pass++;
        @(negedge clk);
        n_checks++; if (obs !== NONE) $display("FAIL async_held: got %b exp %b", obs, NONE); else n_pass++;
        rst_n = 1'b1;
        mem_req_M = 1'b0;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== NONE) $display("FAIL async_fresh_access: got %b exp %b", obs, NONE); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== NONE) $display("FAIL async_one_stall: got %b exp %b", obs, NONE); else n_pass++;
        idle();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) begin
            cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
            n_checks++; if (obs !== HOLD) $display("FAIL tmo_wait_%0d: got %b exp %b", i, obs, HOLD); else n_pass++;
        end
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (obs !== ERR) $display("FAIL tmo_err: got %b exp %b", obs, ERR); else n_pass++;
        cyc(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs !== ERR) $display("FAIL tmo_sticky_ready: got %b exp %b", obs, ERR); else n_pass++;
        cyc(5'd1, 5'd5, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0);
        n_checks++; if (obs !== ERR) $display("FAIL tmo_sticky_idle: got %b exp %b", obs, ERR); else n_pass++;
        do_reset();
        idle();
        n_checks++; if (obs !== NONE) $display("FAIL tmo_cleared: got %b exp %b", obs, NONE); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_mem_priority();
        test_mem_drop();
        test_perf();
        test_async_reset();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
